wb_pia_arbiter: RTL
===================

// Module: wb_pia_arbiter
// PURPOSE
//  Two-master Wishbone arbiter sharing the single wb_pia slave (RIOT I/O + timer)
//  between the 6507 CPU bus master (m0) and the debug/OSD host master (m1).
//  Fixed CPU priority with bounded debug starvation, per-transaction ack timeout,
//  registered slave drive. Sits between the CPU bus decoder and wb_pia.
// PARAMETERS
//  ADR_W    7    address width, passed through to slave
//  TIMEOUT  15   max cycles s_stb_o held without s_ack_i before abort (1..255)
//  STARVE   4    consecutive m0 grants allowed while m1 pending before m1 wins
// PORTS
//  clk_i       in   1      system clock
//  rst_i       in   1      synchronous reset, active-high
//  m0_stb_i    in   1      CPU request, held until m0_ack_o/m0_err_o
//  m0_we_i     in   1      CPU write enable
//  m0_adr_i    in   ADR_W  CPU address
//  m0_dat_i    in   8      CPU write data
//  m0_ack_o    out  1      CPU ack, 1-cycle pulse
//  m0_err_o    out  1      CPU timeout error, 1-cycle pulse
//  m0_dat_o    out  8      CPU read data, valid with m0_ack_o/m0_err_o
//  m1_*                    same set for debug master (stb,we,adr,dat_i,ack,err,dat_o)
//  s_stb_o     out  1      slave strobe
//  s_we_o      out  1      slave write enable
//  s_adr_o     out  ADR_W  slave address
//  s_dat_o     out  8      slave write data
//  s_ack_i     in   1      slave ack
//  s_dat_i     in   8      slave read data
//  owner_o     out  1      current/last owner (0=m0, 1=m1)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; starve_cnt=0; tmo_cnt=0; owner_o=0.
//  FSM IDLE -> BUSY -> RELEASE -> IDLE.
//  IDLE: if no m*_stb_i, stay. Else pick winner:
//   - only one requester: it wins.
//   - both: m1 wins iff starve_cnt==STARVE, else m0 wins.
//   Winner's we/adr/dat registered into s_*; s_stb_o=1 next cycle; owner_o=winner.
//  starve_cnt: +1 on m0 grant while m1_stb_i=1 (saturates at STARVE);
//   cleared on m1 grant or any IDLE cycle with m1_stb_i=0.
//  BUSY: s_stb_o/s_we_o/s_adr_o/s_dat_o held stable; tmo_cnt +1 per cycle.
//   s_ack_i=1: s_stb_o<=0; owner dat_o<=s_dat_i (reads; unchanged on writes);
//    owner ack_o<=1 for one cycle; -> RELEASE.
//   tmo_cnt==TIMEOUT-1 and no ack: s_stb_o<=0; owner dat_o<=8'hFF;
//    owner err_o<=1 one cycle; -> RELEASE. ack wins if both same cycle.
//  RELEASE: one cycle, s_stb_o=0, no grant (master drops stb after ack; the
//   slave's registered ack drains). tmo_cnt<=0. -> IDLE.
//  Latency (read, zero-wait slave): m_stb sampled edge E0; s_stb_o high after E0;
//   slave ack after E1; m_ack_o high after E2 (3 edges). Back-to-back min 4 cycles.
//  Owner drops stb mid-BUSY: slave cycle still completes/times out; ack/err to
//   that master suppressed; dat_o not updated.
//  Non-owner stb changes during BUSY/RELEASE: ignored until next IDLE.
//  s_ack_i outside BUSY: ignored. Never ack/err both masters same cycle.
//  rst_i mid-transaction: next cycle all outputs 0, FSM IDLE, no ack/err pulse.
//  Write to slave may be presented for multiple cycles (stb held until ack);
//   slave side effects must be idempotent (wb_pia timer writes are).
// TESTING
//  1 m0 read adr 0x04, slave returns 0x5A with ack 1 cycle after stb ->
//    m0_ack_o 3 edges after request, m0_dat_o=0x5A, m1 outputs silent.
//  2 m0 and m1 request together continuously, STARVE=4 -> grant order
//    m0,m0,m0,m0,m1,m0,... ; owner_o tracks; each ack to correct master only.
//  3 m1 write adr 0x15 dat 0x20, slave never acks, TIMEOUT=15 -> s_stb_o high
//    exactly 15 cycles, m1_err_o 1-cycle pulse, m1_dat_o=0xFF, FSM back to IDLE.
//  4 ack arrives on cycle TIMEOUT-1 -> ack path taken, no err pulse.
//  5 m0 drops stb one cycle into BUSY -> s_stb_o held to ack, no m0_ack_o.
//  6 rst_i asserted during BUSY -> next cycle s_stb_o=0, no ack/err, fresh
//    request after reset serviced normally with starve_cnt=0.

Source files
------------

// File: rtl/wb_pia_arbiter.sv
// Two-master Wishbone arbiter in front of wb_pia: CPU (m0) has priority, the debug
// master (m1) is guaranteed a slot after STARVE contested CPU grants.
module wb_pia_arbiter #(
    parameter int ADR_W   = 7,
    parameter int TIMEOUT = 15,
    parameter int STARVE  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [7:0]       m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [7:0]       m0_dat_o,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [7:0]       m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [7:0]       m1_dat_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [7:0]       s_dat_o,
    input  logic             s_ack_i,
    input  logic [7:0]       s_dat_i,
    output logic             owner_o
);

    localparam int SW = ($clog2(STARVE + 1) < 1) ? 1 : $clog2(STARVE + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [7:0]      tmo_cnt;
    logic            abandoned;
    logic            grant_m1;
    logic            owner_stb;
    logic            deliver;

    always_comb begin
        grant_m1  = m1_stb_i && (!m0_stb_i || starve_cnt == SW'(STARVE));
        owner_stb = owner_o ? m1_stb_i : m0_stb_i;
        // a master that let go of stb at any point during BUSY gets no response
        deliver   = owner_stb && !abandoned;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            abandoned  <= 1'b0;
            owner_o    <= 1'b0;
            s_stb_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_adr_o    <= '0;
            s_dat_o    <= '0;
            m0_ack_o   <= 1'b0;
            m0_err_o   <= 1'b0;
            m0_dat_o   <= '0;
            m1_ack_o   <= 1'b0;
            m1_err_o   <= 1'b0;
            m1_dat_o   <= '0;
        end else begin
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_stb_i || m1_stb_i) begin
                        owner_o   <= grant_m1;
                        s_stb_o   <= 1'b1;
                        s_we_o    <= grant_m1 ? m1_we_i  : m0_we_i;
                        s_adr_o   <= grant_m1 ? m1_adr_i : m0_adr_i;
                        s_dat_o   <= grant_m1 ? m1_dat_i : m0_dat_i;
                        tmo_cnt   <= '0;
                        abandoned <= 1'b0;
                        state     <= BUSY;
                    end
                    if (grant_m1 || !m1_stb_i)
                        starve_cnt <= '0;
                    else if (starve_cnt != SW'(STARVE))
                        starve_cnt <= starve_cnt + 1'b1;
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (!owner_stb)
                        abandoned <= 1'b1;
                    if (s_ack_i) begin
                        s_stb_o <= 1'b0;
                        state   <= RELEASE;
                        if (deliver) begin
                            if (owner_o) begin
                                m1_ack_o <= 1'b1;
                                if (!s_we_o) m1_dat_o <= s_dat_i;
                            end else begin
                                m0_ack_o <= 1'b1;
                                if (!s_we_o) m0_dat_o <= s_dat_i;
                            end
                        end
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        s_stb_o <= 1'b0;
                        state   <= RELEASE;
                        if (deliver) begin
                            if (owner_o) begin
                                m1_err_o <= 1'b1;
                                m1_dat_o <= 8'hFF;
                            end else begin
                                m0_err_o <= 1'b1;
                                m0_dat_o <= 8'hFF;
                            end
                        end
                    end
                end
                RELEASE: begin
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
